// File: rtl/chdr_fc_pkg.sv
// Shared widths, FSM state type and the credit-fit helper for the CHDR source flow-control gate.
package chdr_fc_pkg;

  localparam int FC_BYTES_W = 64;
  localparam int FC_PKTS_W  = 40;

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PASS  = 2'd2
  } fc_state_e;

  // (sent - acked) wraps mod 2^64; the sum is widened by one bit so it cannot wrap past cap.
  function automatic logic fc_fits(input logic [63:0] sent, input logic [63:0] acked,
                                   input logic [63:0] len, input logic [63:0] cap);
    logic [64:0] need;
    need = {1'b0, sent - acked} + {1'b0, len};
    return need <= {1'b0, cap};
  endfunction

endpackage

// File: rtl/chdr_fc_credit_tracker.sv
// Cumulative sent/acked counters, downstream capacity, packet-fit decision and the sticky
// STRS monotonicity error.
module chdr_fc_credit_tracker
  import chdr_fc_pkg::*;
#(
  parameter int CAP_BYTES_W = 40,
  parameter int CAP_PKTS_W  = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [CAP_BYTES_W-1:0] cap_bytes_i,
  input  logic [CAP_PKTS_W-1:0]  cap_pkts_i,
  input  logic                   admit_i,
  input  logic [15:0]            pkt_len_i,
  input  logic                   strs_en_i,
  input  logic [FC_BYTES_W-1:0]  strs_bytes_i,
  input  logic [FC_PKTS_W-1:0]   strs_pkts_i,
  output logic [FC_BYTES_W-1:0]  sent_bytes_o,
  output logic [FC_PKTS_W-1:0]   sent_pkts_o,
  output logic                   fit_o,
  output logic                   fc_err_o
);

  logic [CAP_BYTES_W-1:0] cap_bytes_q, cap_bytes_d;
  logic [CAP_PKTS_W-1:0]  cap_pkts_q, cap_pkts_d;
  logic [FC_BYTES_W-1:0]  sent_bytes_q, sent_bytes_d, acked_bytes_q, acked_bytes_d;
  logic [FC_PKTS_W-1:0]   sent_pkts_q, sent_pkts_d, acked_pkts_q, acked_pkts_d;
  logic                   fc_err_q, fc_err_d;

  logic [FC_BYTES_W-1:0]  win_bytes, back_bytes;
  logic [FC_PKTS_W-1:0]   win_pkts, back_pkts;
  logic                   strs_ok;

  // An update is monotone when it does not move acked backwards nor past sent.
  assign win_bytes  = sent_bytes_q - acked_bytes_q;
  assign back_bytes = sent_bytes_q - strs_bytes_i;
  assign win_pkts   = sent_pkts_q - acked_pkts_q;
  assign back_pkts  = sent_pkts_q - strs_pkts_i;
  assign strs_ok    = (back_bytes <= win_bytes) && (back_pkts <= win_pkts);

  assign fit_o = fc_fits(sent_bytes_q, acked_bytes_q, 64'(pkt_len_i), 64'(cap_bytes_q))
               & fc_fits(64'(win_pkts), 64'd0, 64'd1, 64'(cap_pkts_q));

  always_comb begin
    cap_bytes_d   = cap_bytes_q;
    cap_pkts_d    = cap_pkts_q;
    sent_bytes_d  = sent_bytes_q;
    sent_pkts_d   = sent_pkts_q;
    acked_bytes_d = acked_bytes_q;
    acked_pkts_d  = acked_pkts_q;
    fc_err_d      = fc_err_q;
    if (load_i) begin
      cap_bytes_d   = cap_bytes_i;
      cap_pkts_d    = cap_pkts_i;
      sent_bytes_d  = '0;
      sent_pkts_d   = '0;
      acked_bytes_d = '0;
      acked_pkts_d  = '0;
      fc_err_d      = 1'b0;
    end else if (strs_en_i) begin
      if (strs_ok) begin
        acked_bytes_d = strs_bytes_i;
        acked_pkts_d  = strs_pkts_i;
      end else begin
        fc_err_d = 1'b1;
      end
    end
    if (admit_i) begin
      sent_bytes_d = sent_bytes_d + 64'(pkt_len_i);
      sent_pkts_d  = sent_pkts_d + 40'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_bytes_q   <= '0;
      cap_pkts_q    <= '0;
      sent_bytes_q  <= '0;
      sent_pkts_q   <= '0;
      acked_bytes_q <= '0;
      acked_pkts_q  <= '0;
      fc_err_q      <= 1'b0;
    end else begin
      cap_bytes_q   <= cap_bytes_d;
      cap_pkts_q    <= cap_pkts_d;
      sent_bytes_q  <= sent_bytes_d;
      sent_pkts_q   <= sent_pkts_d;
      acked_bytes_q <= acked_bytes_d;
      acked_pkts_q  <= acked_pkts_d;
      fc_err_q      <= fc_err_d;
    end
  end

  assign sent_bytes_o = sent_bytes_q;
  assign sent_pkts_o  = sent_pkts_q;
  assign fc_err_o     = fc_err_q;

endmodule

// File: rtl/chdr_src_flow_ctrl.sv
// Source-side CHDR flow-control gate: admits whole packets only when downstream credit allows.
//   state    | meaning
//   ST_UNCFG | no capacity loaded, input blocked
//   ST_IDLE  | packet boundary, head packet gated by credit fit
//   ST_PASS  | inside an admitted packet, beats pass ungated
module chdr_src_flow_ctrl
  import chdr_fc_pkg::*;
#(
  parameter int CHDR_W      = 64,
  parameter int CAP_BYTES_W = 40,
  parameter int CAP_PKTS_W  = 24
) (
  input  logic                   rfnoc_chdr_clk,
  input  logic                   rfnoc_chdr_rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CAP_BYTES_W-1:0] cfg_cap_bytes,
  input  logic [CAP_PKTS_W-1:0]  cfg_cap_pkts,
  input  logic [CHDR_W-1:0]      s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [15:0]            s_axis_pkt_len,
  output logic [CHDR_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic                   strs_valid,
  input  logic [FC_BYTES_W-1:0]  strs_xfer_bytes,
  input  logic [FC_PKTS_W-1:0]   strs_xfer_pkts,
  output logic [FC_BYTES_W-1:0]  sent_bytes,
  output logic [FC_PKTS_W-1:0]   sent_pkts,
  output logic                   stalled,
  output logic                   fc_err
);

  fc_state_e state_q;
  logic      cfg_ready_q;
  logic      fit, load, admit, last_hs;

  assign load    = cfg_valid & cfg_ready_q;
  assign admit   = (state_q == ST_IDLE) & s_axis_tvalid & fit & m_axis_tready;
  assign last_hs = (state_q == ST_PASS) & s_axis_tvalid & m_axis_tready & s_axis_tlast;

  chdr_fc_credit_tracker #(
    .CAP_BYTES_W (CAP_BYTES_W),
    .CAP_PKTS_W  (CAP_PKTS_W)
  ) u_credit (
    .clk_i        (rfnoc_chdr_clk),
    .rst_i        (rfnoc_chdr_rst),
    .load_i       (load),
    .cap_bytes_i  (cfg_cap_bytes),
    .cap_pkts_i   (cfg_cap_pkts),
    .admit_i      (admit),
    .pkt_len_i    (s_axis_pkt_len),
    .strs_en_i    (strs_valid & (state_q != ST_UNCFG)),
    .strs_bytes_i (strs_xfer_bytes),
    .strs_pkts_i  (strs_xfer_pkts),
    .sent_bytes_o (sent_bytes),
    .sent_pkts_o  (sent_pkts),
    .fit_o        (fit),
    .fc_err_o     (fc_err)
  );

  always_ff @(posedge rfnoc_chdr_clk) begin
    if (rfnoc_chdr_rst) begin
      state_q     <= ST_UNCFG;
      cfg_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_UNCFG: if (load) state_q <= ST_IDLE;
        ST_IDLE: begin
          if (admit && !s_axis_tlast) begin
            state_q     <= ST_PASS;
            cfg_ready_q <= 1'b0;
          end
        end
        ST_PASS: begin
          if (last_hs) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_UNCFG;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Zero-latency datapath: only the handshake is gated, and only at packet boundaries.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_axis_tready = fit & m_axis_tready;
        m_axis_tvalid = s_axis_tvalid & fit;
      end
      ST_PASS: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
      end
      default: ;
    endcase
  end

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tlast = s_axis_tlast;
  assign stalled      = (state_q == ST_IDLE) & s_axis_tvalid & ~fit;
  assign cfg_ready    = cfg_ready_q;

endmodule

// File: tb/tb_chdr_src_flow_ctrl.sv
// Directed plus randomized bench for chdr_src_flow_ctrl against a credit-window model;
// a 512-bit instance runs in lockstep and is checked in the reset scenario.
module tb_chdr_src_flow_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cfg_valid, strs_valid, s_tvalid, s_tlast, m_tready;
  logic [39:0] cfg_cap_bytes;
  logic [23:0] cfg_cap_pkts;
  logic [63:0] s_tdata, strs_bytes;
  logic [39:0] strs_pkts;
  logic [15:0] pkt_len;
  logic [511:0] s_tdata5;
  assign s_tdata5 = {8{s_tdata}};

  logic        cfg_ready, s_tready, m_tlast, m_tvalid, stalled, fc_err;
  logic [63:0] m_tdata, sent_bytes;
  logic [39:0] sent_pkts;
  logic         cfg_ready5, s_tready5, m_tlast5, m_tvalid5, stalled5, fc_err5;
  logic [511:0] m_tdata5;
  logic [63:0]  sent_bytes5;
  logic [39:0]  sent_pkts5;

  chdr_src_flow_ctrl #(.CHDR_W(64)) dut (
    .rfnoc_chdr_clk(clk), .rfnoc_chdr_rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_cap_bytes(cfg_cap_bytes), .cfg_cap_pkts(cfg_cap_pkts),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_pkt_len(pkt_len),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .strs_valid(strs_valid), .strs_xfer_bytes(strs_bytes), .strs_xfer_pkts(strs_pkts),
    .sent_bytes(sent_bytes), .sent_pkts(sent_pkts), .stalled(stalled), .fc_err(fc_err));

  chdr_src_flow_ctrl #(.CHDR_W(512)) dut5 (
    .rfnoc_chdr_clk(clk), .rfnoc_chdr_rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready5),
    .cfg_cap_bytes(cfg_cap_bytes), .cfg_cap_pkts(cfg_cap_pkts),
    .s_axis_tdata(s_tdata5), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready5), .s_axis_pkt_len(pkt_len),
    .m_axis_tdata(m_tdata5), .m_axis_tlast(m_tlast5), .m_axis_tvalid(m_tvalid5),
    .m_axis_tready(m_tready),
    .strs_valid(strs_valid), .strs_xfer_bytes(strs_bytes), .strs_xfer_pkts(strs_pkts),
    .sent_bytes(sent_bytes5), .sent_pkts(sent_pkts5), .stalled(stalled5), .fc_err(fc_err5));

  int checks = 0;
  int errors = 0;

  // Reference: credit window = sent - acked, capacity limits, sticky error.
  logic [63:0] md_sent_b = '0, md_ack_b = '0, md_cap_b = '0;
  logic [39:0] md_sent_p = '0, md_ack_p = '0, md_cap_p = '0;
  logic        md_err = 1'b0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic md_fit(input logic [15:0] len);
    logic [63:0] out_b;
    logic [39:0] out_p;
    out_b = md_sent_b - md_ack_b;
    out_p = md_sent_p - md_ack_p;
    return (64'(len) <= md_cap_b) && (out_b <= md_cap_b - 64'(len)) && (out_p < md_cap_p);
  endfunction

  task automatic md_strs(input logic [63:0] nb, input logic [39:0] np);
    logic [63:0] win_b, ahead_b;
    logic [39:0] win_p, ahead_p;
    win_b   = md_sent_b - md_ack_b;
    ahead_b = nb - md_ack_b;
    win_p   = md_sent_p - md_ack_p;
    ahead_p = np - md_ack_p;
    if (ahead_b <= win_b && ahead_p <= win_p) begin
      md_ack_b = nb;
      md_ack_p = np;
    end else begin
      md_err = 1'b1;
    end
  endtask

  task automatic md_load(input logic [39:0] cb, input logic [23:0] cp);
    md_cap_b = 64'(cb); md_cap_p = 40'(cp);
    md_sent_b = '0; md_ack_b = '0; md_sent_p = '0; md_ack_p = '0; md_err = 1'b0;
  endtask

  task automatic configure(input logic [39:0] cb, input logic [23:0] cp);
    cfg_cap_bytes = cb; cfg_cap_pkts = cp; cfg_valid = 1'b1;
    #1 chk("cfg_ready", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    md_load(cb, cp);
    chk("cfg_sent_bytes", sent_bytes, md_sent_b);
    chk("cfg_sent_pkts", sent_pkts, md_sent_p);
    chk("cfg_fc_err", fc_err, md_err);
  endtask

  task automatic strs(input logic [63:0] nb, input logic [39:0] np);
    strs_valid = 1'b1; strs_bytes = nb; strs_pkts = np;
    step();
    strs_valid = 1'b0;
    md_strs(nb, np);
    #1 chk("strs_fc_err", fc_err, md_err);
  endtask

  task automatic send_pkt(input logic [15:0] len, input int nbeats, input bit rand_rdy,
                          input bit cfg_mid, input bit strs_same);
    logic [63:0] d;
    logic        exp_fit, exp_rdy;
    int          guard;
    for (int b = 0; b < nbeats; b++) begin
      d = {$urandom, $urandom};
      s_tdata = d; s_tvalid = 1'b1; s_tlast = (b == nbeats - 1); pkt_len = len;
      guard = 0;
      forever begin
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (b == 0 && strs_same && guard == 0) begin
          strs_valid = 1'b1; strs_bytes = md_sent_b; strs_pkts = md_sent_p;
        end
        #1;
        exp_fit = (b == 0) ? md_fit(len) : 1'b1;
        exp_rdy = exp_fit & m_tready;
        chk("s_tready", s_tready, exp_rdy);
        chk("m_tvalid", m_tvalid, exp_fit);
        if (b == 0) chk("stalled", stalled, !exp_fit);
        if (b > 0 && cfg_mid) chk("cfg_ready_pass", cfg_ready, 1'b0);
        if (exp_rdy) begin
          chk("m_tdata", m_tdata, d);
          chk("m_tlast", m_tlast, s_tlast);
        end
        step();
        if (strs_valid) begin
          md_strs(strs_bytes, strs_pkts);
          strs_valid = 1'b0;
        end
        if (exp_rdy) break;
        guard++;
        if (guard > 64) begin
          checks++; errors++;
          $error("FAIL send_timeout len=%0d beat=%0d", len, b);
          s_tvalid = 1'b0;
          return;
        end
      end
      if (b == 0) begin
        md_sent_b = md_sent_b + 64'(len);
        md_sent_p = md_sent_p + 40'd1;
      end
      if (b == 0 && cfg_mid) cfg_valid = 1'b1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    #1;
    chk("pkt_sent_bytes", sent_bytes, md_sent_b);
    chk("pkt_sent_pkts", sent_pkts, md_sent_p);
    chk("pkt_fc_err", fc_err, md_err);
  endtask

  initial begin
    logic [63:0] d;
    int          r;
    logic [15:0] len;
    rst = 1'b1; cfg_valid = 1'b0; strs_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1; cfg_cap_bytes = '0; cfg_cap_pkts = '0; s_tdata = '0;
    strs_bytes = '0; strs_pkts = '0; pkt_len = '0;
    repeat (3) step();

    // Reset state, with a packet already offered.
    s_tvalid = 1'b1; pkt_len = 16'd8; s_tlast = 1'b1;
    #1;
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_sent_bytes", sent_bytes, 64'd0);
    chk("rst_sent_pkts", sent_pkts, 40'd0);
    chk("rst_stalled", stalled, 1'b0);
    chk("rst_fc_err", fc_err, 1'b0);
    rst = 1'b0;
    step();
    chk("uncfg_s_tready", s_tready, 1'b0);
    chk("uncfg_m_tvalid", m_tvalid, 1'b0);
    s_tvalid = 1'b0; s_tlast = 1'b0;

    // STRS before configuration must be ignored.
    strs_valid = 1'b1; strs_bytes = 64'd5; strs_pkts = 40'd1;
    step();
    strs_valid = 1'b0;
    chk("uncfg_strs_err", fc_err, 1'b0);

    // Three 64-byte packets, then a 128-byte packet that needs credit back.
    configure(40'd256, 24'd8);
    for (int i = 0; i < 3; i++) send_pkt(16'd64, 8, 1'b0, 1'b0, 1'b0);
    chk("t1_sent_bytes", sent_bytes, 64'd192);
    chk("t1_sent_pkts", sent_pkts, 40'd3);
    s_tvalid = 1'b1; s_tlast = 1'b0; pkt_len = 16'd128; m_tready = 1'b1;
    #1;
    chk("t2_blocked", s_tready, 1'b0);
    chk("t2_stalled", stalled, 1'b1);
    strs(64'd64, 40'd1);
    chk("t2_admit_next", s_tready, 1'b1);
    send_pkt(16'd128, 16, 1'b0, 1'b0, 1'b0);
    chk("t2_sent_bytes", sent_bytes, 64'd320);

    // Packet-count limit.
    configure(40'd1048576, 24'd2);
    send_pkt(16'd16, 1, 1'b0, 1'b0, 1'b0);
    send_pkt(16'd16, 1, 1'b0, 1'b0, 1'b0);
    s_tvalid = 1'b1; s_tlast = 1'b1; pkt_len = 16'd16;
    #1;
    chk("t3_stalled", stalled, 1'b1);
    chk("t3_blocked", s_tready, 1'b0);
    strs(64'd16, 40'd1);
    chk("t3_admit_next", s_tready, 1'b1);
    send_pkt(16'd16, 1, 1'b0, 1'b0, 1'b0);

    // Non-monotone STRS: error set, credit window left at acked=100.
    configure(40'd1000, 24'd8);
    send_pkt(16'd64, 8, 1'b0, 1'b0, 1'b0);
    send_pkt(16'd64, 8, 1'b0, 1'b0, 1'b0);
    strs(64'd100, 40'd1);
    strs(64'd50, 40'd1);
    chk("t4_fc_err", fc_err, 1'b1);
    s_tvalid = 1'b1; s_tlast = 1'b1; pkt_len = 16'd973;
    #1 chk("t4_over_by_one", stalled, 1'b1);
    pkt_len = 16'd972;
    #1 chk("t4_exact_fit", stalled, 1'b0);
    s_tvalid = 1'b0;
    configure(40'd256, 24'd8);

    // Backpressure during a packet with a config request held off until tlast.
    cfg_cap_bytes = 40'd512; cfg_cap_pkts = 24'd8;
    send_pkt(16'd64, 8, 1'b1, 1'b1, 1'b0);
    chk("t5_cfg_ready_after", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    md_load(40'd512, 24'd8);
    chk("t5_cfg_cleared", sent_bytes, md_sent_b);

    // Randomized traffic with random STRS, including STRS on the admitting cycle.
    configure(40'($urandom_range(128, 600)), 24'($urandom_range(1, 4)));
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 4));
      len = 16'(8 * $urandom_range(1, 16));
      if (r == 1 && md_sent_b != md_ack_b)
        strs(md_ack_b + 64'($urandom_range(0, int'(md_sent_b - md_ack_b))), md_ack_p);
      else if (r == 2)
        strs(md_ack_b - 64'd1, md_ack_p);
      if (!md_fit(len)) strs(md_sent_b, md_sent_p);
      send_pkt(len, int'(len) / 8, 1'b1, 1'b0, r == 0);
    end

    // Reset in the middle of a packet, on both bus widths.
    configure(40'd256, 24'd8);
    d = {$urandom, $urandom};
    s_tdata = d; s_tvalid = 1'b1; s_tlast = 1'b0; pkt_len = 16'd32; m_tready = 1'b1;
    #1;
    chk("t6_w512_data", m_tdata5, {8{d}});
    chk("t6_w512_valid", m_tvalid5, 1'b1);
    step();
    s_tdata = ~d;
    step();
    chk("t6_pass_bytes", sent_bytes, 64'd32);
    rst = 1'b1;
    step();
    chk("t6_s_tready", s_tready, 1'b0);
    chk("t6_m_tvalid", m_tvalid, 1'b0);
    chk("t6_sent_bytes", sent_bytes, 64'd0);
    chk("t6_sent_pkts", sent_pkts, 40'd0);
    chk("t6_cfg_ready", cfg_ready, 1'b1);
    chk("t6_w512_s_tready", s_tready5, 1'b0);
    chk("t6_w512_m_tvalid", m_tvalid5, 1'b0);
    chk("t6_w512_sent_bytes", sent_bytes5, 64'd0);
    rst = 1'b0;
    step();
    chk("t6_uncfg_hold", s_tready, 1'b0);
    chk("t6_w512_uncfg_hold", s_tready5, 1'b0);
    s_tvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
